// File: rtl/iter_div_unit_if.sv
// Request/response bundle between the EX/MEM datapath and the iterative divider.
interface iter_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;

    modport master (
        output stall, start, op, a, b,
        input  busy, done, r
    );

    modport slave (
        input  stall, start, op, a, b,
        output busy, done, r
    );
endinterface

// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with RV32M corner cases.
// One quotient bit per cycle, sign fix-up in a final cycle, freezable by stall.
module iter_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    iter_div_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] b_abs_q, b_abs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             signed_op, a_neg, b_neg, ovf, res_neg;
    logic [WIDTH-1:0] a_mag, b_mag, res;
    logic [WIDTH:0]   shifted, diff;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r    = r_q;

    // Operand conditioning, one restoring trial subtraction and result selection.
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        ovf       = signed_op && (bus.a == MIN_NEG) && (bus.b == '1);
        // P stays below |b|, so the shifted value fits in WIDTH+1 bits and diff's MSB is its sign.
        shifted   = {p_q, q_q[WIDTH-1]};
        diff      = shifted - {1'b0, b_abs_q};
        res       = op_q[1] ? p_q : q_q;
        res_neg   = op_q[1] ? rsign_q : qsign_q;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_abs_d = b_abs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        r_d     = r_q;

        if (!bus.stall) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_d    = bus.op;
                        b_abs_d = b_mag;
                        qsign_d = a_neg ^ b_neg;
                        rsign_d = a_neg;
                        p_d     = '0;
                        q_d     = a_mag;
                        cnt_d   = '0;
                        if (bus.b == '0) begin
                            r_d     = bus.op[1] ? bus.a : '1;
                            state_d = S_DONE;
                        end else if (ovf) begin
                            r_d     = bus.op[1] ? '0 : bus.a;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (!diff[WIDTH]) begin
                        p_d = diff[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = shifted[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    r_d     = res_neg ? -res : res;
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            b_abs_q <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            p_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_abs_q <= b_abs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_iter_div_unit.sv
// Scoreboard bench for iter_div_unit: arithmetic reference model, randomized stalls and stray starts.
module tb_iter_div_unit;
    localparam int unsigned W = 32;

    typedef struct {
        logic [31:0] r;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    iter_div_if #(.WIDTH(W)) bus ();

    iter_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t        sb[$];
    logic        start_s = 1'b0;
    logic        stall_s = 1'b0;
    logic        rst_s   = 1'b1;
    logic        inflight   = 1'b0;
    logic        model_done = 1'b0;
    logic [31:0] model_r    = '0;
    int          edges      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M division semantics computed directly with language arithmetic.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa, sb_v;
        sa    = $signed(a);
        sb_v  = $signed(b);
        e.lat = W + 1;
        if (b == 32'd0) begin
            e.r   = op[1] ? a : 32'hFFFF_FFFF;
            e.lat = 0;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.r   = op[1] ? 32'd0 : a;
            e.lat = 0;
        end else begin
            case (op)
                2'd0:    e.r = 32'(sa / sb_v);
                2'd1:    e.r = a / b;
                2'd2:    e.r = 32'(sa % sb_v);
                default: e.r = a % b;
            endcase
        end
        return e;
    endfunction

    // Inputs seen by the DUT at each active edge.
    always @(posedge clk) begin
        rst_s   = rst;
        stall_s = bus.stall;
        start_s = bus.start;
    end

    // Monitor: advance the abstract model by one edge, then compare DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst_s) begin
            if (inflight && sb.size() > 0) e = sb.pop_front();
            inflight   = 1'b0;
            model_done = 1'b0;
            model_r    = '0;
        end else if (!stall_s) begin
            if (start_s && !inflight) begin
                model_done = 1'b0;
                if (sb.size() == 0) begin
                    chk("accept_without_expectation", 32'd1, 32'd0);
                end else begin
                    inflight = 1'b1;
                    edges    = 0;
                end
            end else if (inflight) begin
                edges++;
            end else begin
                model_done = 1'b0;
            end
        end
        if (inflight && sb.size() > 0 && edges == sb[0].lat) begin
            e          = sb.pop_front();
            inflight   = 1'b0;
            model_done = 1'b1;
            model_r    = e.r;
        end
        chk("busy", 32'(bus.busy), 32'(inflight));
        chk("done", 32'(bus.done), 32'(model_done));
        chk("r", bus.r, model_r);
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        exp_t e;
        e   = ref_model(op, a, b);
        lat = e.lat;
        sb.push_back(e);
        bus.stall = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom();
        bus.b     = $urandom();
    endtask

    // mode 0: quiet, 1: random stalls and stray starts, 2: scripted stall burst and stray starts.
    task automatic wait_done(input int mode, input int lat, output int n);
        int   nst;
        logic stray;
        nst = 0;
        n   = 0;
        while (bus.done !== 1'b1) begin
            if (n > 300) begin
                chk("done_timeout", 32'(n), 32'(lat + nst));
                break;
            end
            bus.stall = 1'b0;
            stray     = 1'b0;
            if (mode == 1) begin
                bus.stall = ($urandom_range(0, 3) == 0);
                stray     = (n < 20) && ($urandom_range(0, 2) == 0);
            end else if (mode == 2) begin
                bus.stall = (n >= 10 && n <= 12);
                stray     = (n == 5 || n == 6 || n == 15);
            end
            bus.start = stray;
            if (stray) begin
                bus.op = 2'($urandom_range(0, 3));
                bus.a  = $urandom();
                bus.b  = $urandom_range(0, 3);
            end
            if (bus.stall) nst++;
            @(negedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        chk("latency", 32'(n), 32'(lat + nst));
    endtask

    task automatic run_dir(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input int exp_lat);
        int lat, n;
        issue(op, a, b, lat);
        wait_done(0, lat, n);
        chk("dir_latency", 32'(n), 32'(exp_lat));
        chk("dir_r", bus.r, exp_r);
    endtask

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'($urandom_range(0, 20));
            2:       return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] pick_b();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 9));
            3:       return -32'($urandom_range(1, 9));
            4:       return $urandom() >> $urandom_range(0, 31);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat, n;
        rst       = 1'b1;
        bus.stall = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_r", bus.r, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        run_dir(2'd1, 32'd100, 32'd7, 32'd14, W + 1);
        run_dir(2'd3, 32'd100, 32'd7, 32'd2, W + 1);
        run_dir(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, W + 1);
        run_dir(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, W + 1);
        run_dir(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_dir(2'd2, 32'd5, 32'd0, 32'd5, 0);
        run_dir(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_dir(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_dir(2'd3, 32'd7, 32'd100, 32'd7, W + 1);

        // Three-cycle stall mid-calculation with start pulses while busy.
        issue(2'd1, 32'd100, 32'd7, lat);
        wait_done(2, lat, n);
        chk("stall_latency", 32'(n), 32'(W + 4));
        chk("stall_r", bus.r, 32'd14);
        repeat (2) begin @(negedge clk); #1; end

        // Reset in the middle of an operation, then a fresh division.
        issue(2'd1, 32'd100, 32'd7, lat);
        repeat (9) begin @(negedge clk); #1; end
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_r", bus.r, 32'd0);
        run_dir(2'd1, 32'd9, 32'd3, 32'd3, W + 1);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick_a(), pick_b(), lat);
            wait_done(1, lat, n);
            repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
        end

        repeat (3) begin @(negedge clk); #1; end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
